// File: rtl/fft_sink_pkg.sv
// Shared definitions for the FFT frame sink: write-FSM encoding, size defaults
// and the re/im field layout of one bin beat.
package fft_sink_pkg;

    localparam int FFT_LEN_DEF = 256;
    localparam int DATA_W_DEF  = 32;

    // Beat layout: {im[31:16], re[15:0]}
    localparam int RE_LSB = 0;
    localparam int RE_W   = 16;
    localparam int IM_LSB = 16;
    localparam int IM_W   = 16;

    typedef enum logic {
        WR_RECV = 1'b0,
        WR_DROP = 1'b1
    } wr_state_e;

endpackage

// File: rtl/fft_sink_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// The caller places the bank select in the address MSB.
module fft_sink_ram #(
    parameter int DEPTH  = 512,
    parameter int DATA_W = 32,
    parameter int AW     = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: no reset on the array or its read register, so the store maps onto
    // block RAM; sequential state is always written with non-blocking '<='.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_frame_sink.sv
// Ping-pong frame sink: captures AXI-Stream FFT frames into two banks and
// hands complete frames to a random-access reader released by frame_ack.
module fft_frame_sink
    import fft_sink_pkg::*;
#(
    parameter int FFT_LEN = FFT_LEN_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int AW      = $clog2(FFT_LEN)
) (
    input  logic              m_axis_aclk,
    input  logic              m_axis_aresetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_ready,
    input  logic              frame_ack,
    output logic              err_short,
    output logic              err_long,
    input  logic              err_clr,
    output logic [15:0]       frame_cnt
);

    localparam logic [AW-1:0] BIN_LAST = AW'(FFT_LEN - 1);

    wr_state_e         state, state_d;
    logic [AW-1:0]     bin_cnt;
    logic              wr_bank, rd_bank;
    logic [1:0]        full;
    logic              run;      // low during reset so tready stays deasserted
    logic              rd_seen;  // forces rd_data to zero until the first read
    logic [DATA_W-1:0] ram_q;

    logic accept, ram_we, frame_done, set_short, set_long, bin_clr, bin_inc;
    logic ack_take;

    assign accept      = s_axis_tvalid && s_axis_tready;
    assign ack_take    = frame_ack && full[rd_bank];
    assign frame_ready = full[rd_bank];
    assign rd_data     = rd_seen ? ram_q : '0;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state;
        s_axis_tready = 1'b0;
        ram_we        = 1'b0;
        frame_done    = 1'b0;
        set_short     = 1'b0;
        set_long      = 1'b0;
        bin_clr       = 1'b0;
        bin_inc       = 1'b0;
        unique case (state)
            WR_RECV: begin
                s_axis_tready = run && !full[wr_bank];
                if (accept) begin
                    ram_we  = 1'b1;
                    bin_clr = (bin_cnt == BIN_LAST) || s_axis_tlast;
                    bin_inc = !bin_clr;
                    if (bin_cnt == BIN_LAST) begin
                        frame_done = s_axis_tlast;
                        set_long   = !s_axis_tlast;
                        if (!s_axis_tlast) state_d = WR_DROP;
                    end else begin
                        set_short = s_axis_tlast;
                    end
                end
            end
            WR_DROP: begin
                s_axis_tready = run;
                if (accept && s_axis_tlast) state_d = WR_RECV;
            end
            default: state_d = WR_RECV;
        endcase
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state     <= WR_RECV;
            bin_cnt   <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            full      <= 2'b00;
            run       <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            frame_cnt <= '0;
            rd_seen   <= 1'b0;
        end else begin
            state <= state_d;
            run   <= 1'b1;
            if (bin_clr)      bin_cnt <= '0;
            else if (bin_inc) bin_cnt <= bin_cnt + AW'(1);
            // Completion and ack always target different banks, so both apply.
            if (frame_done) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
                frame_cnt     <= frame_cnt + 16'd1;
            end
            if (ack_take) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
            if (set_short)    err_short <= 1'b1;
            else if (err_clr) err_short <= 1'b0;
            if (set_long)     err_long  <= 1'b1;
            else if (err_clr) err_long  <= 1'b0;
            if (rd_en) rd_seen <= 1'b1;
        end
    end

    fft_sink_ram #(
        .DEPTH  (2 * FFT_LEN),
        .DATA_W (DATA_W),
        .AW     (AW + 1)
    ) u_ram (
        .clk   (m_axis_aclk),
        .we    (ram_we),
        .waddr ({wr_bank, bin_cnt}),
        .wdata (s_axis_tdata),
        .re    (rd_en),
        .raddr ({rd_bank, rd_addr}),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_fft_frame_sink.sv
// Self-checking bench for fft_frame_sink: a queue-of-frames model predicts
// handshake, flags, counters and read data every cycle.
module tb_fft_frame_sink;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        frame_ready;
    logic        frame_ack = 1'b0;
    logic        err_short, err_long;
    logic        err_clr = 1'b0;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    fft_frame_sink dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rst_n),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .frame_ready    (frame_ready),
        .frame_ack      (frame_ack),
        .err_short      (err_short),
        .err_long       (err_long),
        .err_clr        (err_clr),
        .frame_cnt      (frame_cnt)
    );

    // Model: completed frames awaiting the reader, oldest first (at most two).
    typedef logic [31:0] frame_t [N];
    frame_t      fifo[$];
    frame_t      cur;
    int          cur_n;
    bit          dropping, m_short, m_long, rd_known, last_acc;
    logic [15:0] m_cnt;
    logic [31:0] exp_rd;
    int          checks = 0;
    int          errors = 0;

    // Side-band requests consumed by the next cycle() call.
    logic       ack_nx = 1'b0, clr_nx = 1'b0, ren_nx = 1'b0;
    logic [7:0] ra_nx = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_beat(input logic [31:0] d, input logic l);
        if (dropping) begin
            if (l) dropping = 1'b0;
            return;
        end
        cur[cur_n] = d;
        if (cur_n == N - 1) begin
            cur_n = 0;
            if (l) begin
                fifo.push_back(cur);
                m_cnt++;
            end else begin
                m_long   = 1'b1;
                dropping = 1'b1;
            end
        end else if (l) begin
            cur_n   = 0;
            m_short = 1'b1;
        end else begin
            cur_n++;
        end
    endtask

    task automatic check_outputs();
        check("frame_ready", frame_ready, fifo.size() > 0);
        check("frame_cnt", frame_cnt, m_cnt);
        check("err_short", err_short, m_short);
        check("err_long", err_long, m_long);
        if (rd_known) check("rd_data", rd_data, exp_rd);
    endtask

    // One clock: called and returning at a falling edge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic l);
        bit acc;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        frame_ack     = ack_nx;
        err_clr       = clr_nx;
        rd_en         = ren_nx;
        rd_addr       = ra_nx;
        check("tready", s_axis_tready, dropping || fifo.size() < 2);
        acc      = v && s_axis_tready;
        last_acc = acc;
        @(posedge clk);
        if (ren_nx) begin
            rd_known = fifo.size() > 0;
            if (rd_known) exp_rd = fifo[0][ra_nx];
        end
        if (clr_nx) begin
            m_short = 1'b0;
            m_long  = 1'b0;
        end
        if (ack_nx && fifo.size() > 0) fifo.delete(0);
        if (acc) model_beat(d, l);
        ack_nx = 1'b0;
        clr_nx = 1'b0;
        ren_nx = 1'b0;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        for (int t = 0; t < 1000; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                ren_nx = 1'b1;
                ra_nx  = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                cycle(1'b0, 32'($urandom), 1'b0);
            end else begin
                cycle(1'b1, d, l);
                if (last_acc) return;
            end
        end
        check("send_timeout", last_acc, 1);
    endtask

    task automatic send_frame(input int n, input int last_at, input bit ramp);
        for (int i = 0; i < n; i++) send_beat(ramp ? 32'(i) : 32'($urandom), i == last_at);
    endtask

    task automatic drain();
        for (int g = 0; g < 4 && fifo.size() > 0; g++) begin
            for (int r = 0; r < 6; r++) begin
                ren_nx = 1'b1;
                ra_nx  = 8'($urandom);
                cycle(1'b0, '0, 1'b0);
            end
            ack_nx = 1'b1;
            cycle(1'b0, '0, 1'b0);
        end
        check("drained", frame_ready, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; frame_ack = 1'b0;
        err_clr = 1'b0; rd_en = 1'b0;
        #1;
        check("rst_tready", s_axis_tready, 0);
        check("rst_frame_ready", frame_ready, 0);
        check("rst_err_short", err_short, 0);
        check("rst_err_long", err_long, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_rd_data", rd_data, 0);
        fifo.delete();
        cur_n = 0; dropping = 0; m_short = 0; m_long = 0; m_cnt = '0;
        exp_rd = '0; rd_known = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_hold_tready", s_axis_tready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_tready", s_axis_tready, 1);
        check_outputs();
    endtask

    frame_t f3;

    initial begin
        // Power-on reset and a ramp frame; bin 0x2A reads back its index.
        do_reset();
        send_frame(N, N - 1, 1'b1);
        check("f1_cnt", frame_cnt, 1);
        ren_nx = 1'b1; ra_nx = 8'h2A;
        cycle(1'b0, '0, 1'b0);
        check("rd_2a", rd_data, 32'h0000_002A);
        cycle(1'b0, '0, 1'b0);
        check("rd_hold", rd_data, 32'h0000_002A);
        ack_nx = 1'b1;
        cycle(1'b0, '0, 1'b0);

        // Two frames fill both banks; a third stalls until the first ack.
        send_frame(N, N - 1, 1'b0);
        send_frame(N, N - 1, 1'b0);
        check("both_full_tready", s_axis_tready, 0);
        foreach (f3[i]) f3[i] = $urandom;
        repeat (5) cycle(1'b1, f3[0], 1'b0);
        check("stalled", last_acc, 0);
        ack_nx = 1'b1;
        cycle(1'b1, f3[0], 1'b0);
        check("ack_cycle_stall", last_acc, 0);
        check("tready_after_ack", s_axis_tready, 1);
        for (int i = 0; i < N; i++) send_beat(f3[i], i == N - 1);
        drain();

        // Short frame with a coincident err_clr: the set wins.
        send_frame(100, -1, 1'b0);
        clr_nx = 1'b1;
        cycle(1'b1, 32'($urandom), 1'b1);
        check("short_accepted", last_acc, 1);
        check("short_flag", err_short, 1);
        check("short_no_frame", frame_ready, 0);
        send_frame(N, N - 1, 1'b0);
        drain();

        // Long frame: overflow beats dropped until tlast, then err_clr.
        send_frame(300, 299, 1'b0);
        check("long_flag", err_long, 1);
        clr_nx = 1'b1;
        cycle(1'b0, '0, 1'b0);
        check("long_cleared", err_long, 0);
        send_frame(N, N - 1, 1'b0);
        drain();

        // Completion on one bank coincident with ack of the other.
        send_frame(N, N - 1, 1'b0);
        send_frame(N - 1, -1, 1'b0);
        ack_nx = 1'b1;
        cycle(1'b1, 32'($urandom), 1'b1);
        check("coincident_accepted", last_acc, 1);
        check("coincident_ready", frame_ready, 1);
        drain();

        // Reset mid-frame, then a clean frame counts from one.
        send_frame(128, -1, 1'b0);
        do_reset();
        send_frame(N, N - 1, 1'b1);
        check("post_reset_cnt", frame_cnt, 1);
        drain();

        // Random mix of frame lengths.
        for (int k = 0; k < 4; k++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N - 1)) : N;
            send_frame(len, len - 1, 1'b0);
            if ($urandom_range(0, 1) == 0) drain();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_frame_sink.md
FFT_FRAME_SINK -- requirements
Module: fft_frame_sink

Interface
REQ-001 Parameter FFT_LEN, default 256, meaning bins per frame (power of two, 16..4096).
REQ-002 Parameter DATA_W, default 32, meaning beat width: {im[31:16], re[15:0]}.
REQ-003 m_axis_aclk  in  1  single clock; all logic rising-edge.
REQ-004 m_axis_aresetn  in  1  reset; asynchronous assert, active-low.
REQ-005 s_axis_tdata  in  DATA_W  FFT bin sample.
REQ-006 s_axis_tvalid  in  1  upstream beat valid.
REQ-007 s_axis_tready  out  1  sink accepts beat.
REQ-008 s_axis_tlast  in  1  last bin of frame.
REQ-009 rd_en  in  1  read strobe into the current read bank.
REQ-010 rd_addr  in  log2(FFT_LEN)  bin index to read.
REQ-011 rd_data  out  DATA_W  bin data, 1-cycle latency.
REQ-012 frame_ready  out  1  read bank holds a complete frame.
REQ-013 frame_ack  in  1  single-cycle pulse releasing the read bank.
REQ-014 err_short  out  1  sticky: tlast before bin FFT_LEN-1.
REQ-015 err_long  out  1  sticky: no tlast on bin FFT_LEN-1.
REQ-016 err_clr  in  1  single-cycle pulse clearing both error flags.
REQ-017 frame_cnt  out  16  count of completed frames, wraps 0xFFFF->0.

Function
REQ-018 Storage: two banks (ping-pong) of FFT_LEN x DATA_W; state per bank: full/empty.
REQ-019 Beat accepted iff s_axis_tvalid && s_axis_tready on a rising edge.
REQ-020 Write FSM states: RECV, DROP; reset state RECV.
REQ-021 RECV: s_axis_tready = !full[wr_bank]; each accepted beat writes mem[wr_bank][bin_cnt], bin_cnt++.
REQ-022 RECV, accepted beat, tlast=1, bin_cnt=FFT_LEN-1: full[wr_bank] set, wr_bank toggles, bin_cnt=0, frame_cnt++, all effective on the next cycle.
REQ-023 RECV, accepted beat, tlast=1, bin_cnt<FFT_LEN-1: err_short set, bin_cnt=0, bank stays empty, frame discarded, FSM stays in RECV.
REQ-024 RECV, accepted beat, tlast=0, bin_cnt=FFT_LEN-1: err_long set, bank stays empty, bin_cnt=0, go to DROP.
REQ-025 DROP: s_axis_tready=1; beats discarded, no writes; accepted tlast=1 beat returns FSM to RECV.
REQ-026 Read bank rd_bank: frame_ready = full[rd_bank]; rd_data <= mem[rd_bank][rd_addr] one cycle after rd_en; rd_data holds when rd_en=0.
REQ-027 frame_ack while frame_ready: clear full[rd_bank], toggle rd_bank, next cycle. frame_ack while !frame_ready: ignored.
REQ-028 Frame completion and frame_ack in the same cycle act on different banks; both take effect.
REQ-029 When both banks are full, s_axis_tready=0 until frame_ack; there is no overflow loss.
REQ-030 err_clr and an error event in the same cycle: the set takes priority.
REQ-031 Sustained throughput is one beat per cycle while a write bank is free.

Reset
REQ-032 Asserting m_axis_aresetn=0 at any time, including mid-frame, forces:
- FSM = RECV; bin_cnt = 0; wr_bank = rd_bank = 0; full = 00.
- s_axis_tready = 0 while in reset; 1 on the first cycle after release.
- frame_ready = 0; err_short = err_long = 0; frame_cnt = 0; rd_data = 0.
REQ-033 RAM contents are not reset; a partial frame cut off by reset is lost.

Structure
REQ-034 Shared package fft_sink_pkg holds the FSM state encoding, the FFT_LEN/DATA_W defaults and the re/im field positions.
REQ-035 Storage is a single sub-module fft_sink_ram: simple dual-port, 2*FFT_LEN deep, bank bit as the address MSB, synchronous read, block-RAM inferable.

Verification
REQ-036 Reset, then 256 beats with tdata=bin index and tlast on beat 255 -> frame_ready=1 one cycle later, frame_cnt=1; reading addr 0x2A returns 0x0000002A.
REQ-037 Three back-to-back frames with no ack -> tready drops after frame 2's last beat; frame 3 stalls; first ack reasserts tready next cycle; frame 3 data arrives intact.
REQ-038 tlast on beat 100 -> err_short=1, frame_ready stays 0, frame_cnt unchanged; next full frame stored normally.
REQ-039 300 beats with tlast only on beat 299 -> err_long=1 after beat 255; beats 256-299 dropped; FSM back in RECV; err_clr pulse -> err_long=0.
REQ-040 Reset asserted at beat 128 -> all outputs at reset values immediately; next full frame completes with frame_cnt=1.
REQ-041 Frame completion on bank 1 coincident with frame_ack of bank 0 -> full=10, rd_bank=1, frame_ready stays 1.
